// File: rtl/adder_pipe_nbit.sv
// ---------------------------------------------------------------------------
// adder_pipe_nbit
//
// Pipelined N-bit adder. The NUMB_BITS-wide add of a + b + carry_in is split
// into NUM_STAGES chunks of C = NUMB_BITS/NUM_STAGES bits. Each stage adds
// one chunk and registers the result. The carry out of that chunk feeds the
// next stage. The operand slices that are still unprocessed travel with the
// transaction.
//
// Parameters
//   NUMB_BITS   operand/sum width. Must be >= 2 and a multiple of NUM_STAGES.
//   NUM_STAGES  number of register stages. Must be >= 1.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset. Discards every transaction
//                that is in flight.
//   in_valid     operands a/b/carry_in/signed_mode are present
//   in_ready     the block accepts operands this cycle
//   a, b         operands
//   carry_in     carry into bit 0
//   signed_mode  overflow rule for this transaction:
//                  1 = two's complement, 0 = unsigned
//   out_valid    sum/carry_out/overflow are present
//   out_ready    the consumer accepts the result this cycle
//   sum          a + b + carry_in, modulo 2^NUMB_BITS
//   carry_out    carry out of the MSB
//   overflow     unsigned mode: carry_out.
//                signed mode: carry into the MSB XOR carry out of the MSB.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1, on either side. A producer holds valid and its data until that
// transfer happens. in_ready depends combinationally on out_ready through the
// per-stage load chain, so a bubble anywhere in the pipe can be filled while
// the output is stalled. A full pipe can also accept and emit in the same
// cycle. The outputs come straight from the last stage's registers.
// ---------------------------------------------------------------------------
module adder_pipe_nbit #(
    parameter int NUMB_BITS  = 16,
    parameter int NUM_STAGES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUMB_BITS-1:0] a,
    input  logic [NUMB_BITS-1:0] b,
    input  logic                 carry_in,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUMB_BITS-1:0] sum,
    output logic                 carry_out,
    output logic                 overflow
);

    localparam int C    = NUMB_BITS / NUM_STAGES;
    localparam int LAST = NUM_STAGES - 1;

    genvar k;
    for (k = 0; k < NUM_STAGES; k++) begin : g_stage
        // W: sum bits resolved once this stage holds the transaction.
        // REM: operand bits still waiting for later stages.
        localparam int W   = (k + 1) * C;
        localparam int REM = NUMB_BITS - W;

        logic         ld;
        logic         src_v;
        logic         src_c;
        logic         src_m;
        logic [C-1:0] src_a;
        logic [C-1:0] src_b;
        logic [C:0]   res;
        logic [W-1:0] s_d;

        logic         v_q;
        logic         c_q;
        logic [W-1:0] s_q;

        if (k == 0) begin : g_src
            assign src_v = in_valid;
            assign src_c = carry_in;
            assign src_m = signed_mode;
            assign src_a = a[C-1:0];
            assign src_b = b[C-1:0];
            assign s_d   = res[C-1:0];
        end else begin : g_src
            assign src_v = g_stage[k-1].v_q;
            assign src_c = g_stage[k-1].c_q;
            assign src_m = g_stage[k-1].g_rem.m_q;
            assign src_a = g_stage[k-1].g_rem.a_q[C-1:0];
            assign src_b = g_stage[k-1].g_rem.b_q[C-1:0];
            assign s_d   = {res[C-1:0], g_stage[k-1].s_q};
        end

        // Chunk add. res[C] is the carry handed to the next chunk.
        assign res = {1'b0, src_a} + {1'b0, src_b} + {{C{1'b0}}, src_c};

        // A stage may load when it is empty or when its content moves on
        // in this same cycle.
        if (k == LAST) begin : g_ld
            assign ld = !v_q || out_ready;
        end else begin : g_ld
            assign ld = !v_q || g_stage[k+1].ld;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                s_q <= '0;
                c_q <= 1'b0;
            end else if (ld) begin
                v_q <= src_v;
                // With no valid upstream data the stage becomes a bubble.
                // The data registers keep their old contents.
                if (src_v) begin
                    s_q <= s_d;
                    c_q <= res[C];
                end
            end
        end

        if (REM > 0) begin : g_rem
            // Operand bits not yet added, plus the mode captured on accept.
            logic [REM-1:0] a_d;
            logic [REM-1:0] b_d;
            logic [REM-1:0] a_q;
            logic [REM-1:0] b_q;
            logic           m_q;

            if (k == 0) begin : g_up
                assign a_d = a[NUMB_BITS-1:C];
                assign b_d = b[NUMB_BITS-1:C];
            end else begin : g_up
                assign a_d = g_stage[k-1].g_rem.a_q[REM+C-1:C];
                assign b_d = g_stage[k-1].g_rem.b_q[REM+C-1:C];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                    m_q <= 1'b0;
                end else if (ld && src_v) begin
                    a_q <= a_d;
                    b_q <= b_d;
                    m_q <= src_m;
                end
            end
        end else begin : g_last
            // Carry into the MSB, recovered from the MSB sum bit:
            // s = a ^ b ^ cin, so cin = a ^ b ^ s.
            logic msb_cin;
            logic ovf_q;

            assign msb_cin = src_a[C-1] ^ src_b[C-1] ^ res[C-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (ld && src_v) begin
                    ovf_q <= src_m ? (msb_cin ^ res[C]) : res[C];
                end
            end
        end
    end

    assign in_ready  = g_stage[0].ld;
    assign out_valid = g_stage[LAST].v_q;
    assign sum       = g_stage[LAST].s_q;
    assign carry_out = g_stage[LAST].c_q;
    assign overflow  = g_stage[LAST].g_last.ovf_q;

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// ---------------------------------------------------------------------------
// tb_adder_pipe_nbit
//
// Directed and random stimulus for adder_pipe_nbit with its default
// parameters (16 bits, 4 stages). Every accepted input pushes a result
// computed by a reference model into exp_q. Every emitted output pops exp_q
// and is compared against the popped result.
// ---------------------------------------------------------------------------
module tb_adder_pipe_nbit;

    localparam int N = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         carry_in;
    logic         signed_mode;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         carry_out;
    logic         overflow;

    logic [N+1:0] exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           n_acc = 0;

    logic [N-1:0] pa[6] = '{16'h1234, 16'h8001, 16'hFFFF, 16'h0F0F, 16'h7FFF, 16'hAAAA};
    logic [N-1:0] pb[6] = '{16'h4321, 16'h8001, 16'h0002, 16'hF0F1, 16'h7FFF, 16'h5556};

    adder_pipe_nbit #(
        .NUMB_BITS  (N),
        .NUM_STAGES (S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .carry_in    (carry_in),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sum         (sum),
        .carry_out   (carry_out),
        .overflow    (overflow)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Returns {sum, carry_out, overflow}.
    function automatic logic [N+1:0] ref_add(input logic [N-1:0] x, input logic [N-1:0] y,
                                             input logic ci, input logic m);
        logic [N:0] full;
        logic       ovf;
        full = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
        if (m) ovf = (x[N-1] == y[N-1]) && (full[N-1] != x[N-1]);
        else   ovf = full[N];
        return {full[N-1:0], full[N], ovf};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock cycle. Handshakes are evaluated at the falling edge, where
    // the inputs and the DUT outputs are stable. They take effect at the
    // next rising edge. Control returns 1 time unit after that edge.
    task automatic cycle();
        logic [N+1:0] e;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_add(a, b, carry_in, signed_mode));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                check("emit_has_expect", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("emit_result", 32'({sum, carry_out, overflow}), 32'(e));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // One transaction into an idle pipe. Checks its latency and the
    // directed expected values, then retires it.
    task automatic single(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci,
                          input logic m, input logic [N-1:0] es, input logic ec,
                          input logic eo);
        int lat;
        out_ready   = 1'b1;
        a           = x;
        b           = y;
        carry_in    = ci;
        signed_mode = m;
        in_valid    = 1'b1;
        #1;
        check("single_in_ready", 32'(in_ready), 32'd1);
        cycle();
        in_valid = 1'b0;
        a        = $urandom_range(0, 16'hFFFF);
        b        = $urandom_range(0, 16'hFFFF);
        lat      = 0;
        while (!out_valid && lat < 20) begin
            cycle();
            lat++;
        end
        check("single_latency", 32'(lat), 32'(S - 1));
        check("single_sum", 32'(sum), 32'(es));
        check("single_carry_out", 32'(carry_out), 32'(ec));
        check("single_overflow", 32'(overflow), 32'(eo));
        cycle();
    endtask

    initial begin
        int           idx;
        int           prev;
        int           sent;
        int           guard;
        logic [N+1:0] hold;

        rst         = 1'b1;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        carry_in    = 1'b0;
        signed_mode = 1'b0;
        out_ready   = 1'b1;
        repeat (2) cycle();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_carry_out", 32'(carry_out), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // ---------------- directed arithmetic ----------------
        single(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        single(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        single(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        single(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        single(16'h8000, 16'hFFFF, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        single(16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);

        // ---------------- fill under backpressure ----------------
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        carry_in    = 1'b0;
        signed_mode = 1'b0;
        idx         = 0;
        for (int i = 0; i < 8; i++) begin
            a    = pa[idx];
            b    = pb[idx];
            prev = n_acc;
            cycle();
            if (n_acc != prev) idx++;
        end
        check("stall_accepted", 32'(idx), 32'd4);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        hold = {sum, carry_out, overflow};
        repeat (3) cycle();
        check("stall_hold", 32'({sum, carry_out, overflow}), 32'(hold));

        // Release the stall. The remaining two pairs go in while the full
        // pipe drains.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (idx < 6) begin
                a = pa[idx];
                b = pb[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("drain_in_ready", 32'(in_ready), 32'd1);
            check("drain_out_valid", 32'(out_valid), 32'd1);
            prev = n_acc;
            cycle();
            if (n_acc != prev) idx++;
        end
        in_valid = 1'b0;
        check("drain_all_accepted", 32'(idx), 32'd6);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_out_valid_low", 32'(out_valid), 32'd0);

        // ---------------- random streaming ----------------
        sent  = 0;
        guard = 0;
        while ((sent < 20 || exp_q.size() != 0) && guard < 2000) begin
            in_valid    = (sent < 20) && ($urandom_range(0, 1) == 1);
            a           = $urandom_range(0, 16'hFFFF);
            b           = $urandom_range(0, 16'hFFFF);
            carry_in    = $urandom_range(0, 1);
            signed_mode = $urandom_range(0, 1);
            out_ready   = $urandom_range(0, 1);
            prev        = n_acc;
            cycle();
            sent  += n_acc - prev;
            guard++;
        end
        in_valid = 1'b0;
        check("stream_sent", 32'(sent), 32'd20);
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // ---------------- reset with transactions in flight ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a           = pa[i];
            b           = pb[i];
            carry_in    = 1'b1;
            signed_mode = 1'b0;
            cycle();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        cycle();
        rst = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_sum", 32'(sum), 32'd0);
        out_ready = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check("flush_no_emit", 32'(out_valid), 32'd0);
            cycle();
        end
        single(16'h1234, 16'h0FCC, 1'b0, 1'b0, 16'h2200, 1'b0, 1'b0);
        check("final_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/adder_pipe_nbit.md
Name: adder_pipe_nbit

Overview:
- Pipelined, parametrised successor to the team's combinational ripple-carry N-bit adder.
- Splits the N-bit add into NUM_STAGES carry-propagating chunks with one register stage per chunk.
- Uses valid/ready handshakes on both sides with full backpressure.
- Reports unsigned or signed overflow per transaction. Used where a wide add cannot close timing in one cycle.

Parameters:
- NUMB_BITS, 16, operand/sum width; must be >= 2 and a multiple of NUM_STAGES.
- NUM_STAGES, 4, number of pipeline stages; chunk width C = NUMB_BITS/NUM_STAGES; must be >= 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  NUMB_BITS  operand A.
- b  input  NUMB_BITS  operand B.
- carry_in  input  1  carry into bit 0.
- signed_mode  input  1  1 = two's-complement overflow rule, 0 = unsigned rule; captured with the operands.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result this cycle.
- sum  output  NUMB_BITS  a + b + carry_in, modulo 2^NUMB_BITS.
- carry_out  output  1  carry out of the MSB.
- overflow  output  1  unsigned mode: carry_out; signed mode: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: when rst=1 at a clock edge, all stage valid bits clear. out_valid=0, sum=0, carry_out=0, overflow=0. in_ready=1 in the cycle after reset deasserts.
- Reset wins over any simultaneous handshake. Transactions in flight are discarded, never emitted.
- Stage k (0..NUM_STAGES-1) holds: valid; sum bits [(k+1)C-1:0]; running carry; signed_mode; unprocessed a/b upper slices.
- Stage k adds chunk k of a and b using the carry from stage k-1. Stage 0 uses carry_in.
- The last stage also records the carry into the MSB.
- The last stage register drives sum, carry_out and overflow directly. No combinational logic from a or b reaches the outputs.
- Load rule:
  - Last stage loads when !valid[last] || out_ready.
  - Stage k loads when !valid[k] || load[k+1].
  - in_ready = load[0]. The ready path is combinational from out_ready (bubble-collapsing).
- Accept: an input is taken when in_valid && in_ready. Emit: an output is retired when out_valid && out_ready.
- A stage that loads with no valid upstream data becomes invalid (bubble).
- Latency: a transaction accepted at edge t is presented with out_valid=1 after edge t+NUM_STAGES-1, i.e. NUM_STAGES cycles after acceptance.
- Throughput: 1 transaction per cycle while out_ready=1.
- Capacity: NUM_STAGES transactions. With out_ready=0, in_ready falls once every stage is valid.
- Backpressure: while out_valid=1 and out_ready=0, sum, carry_out and overflow hold stable. Results leave strictly in acceptance order.
- Simultaneous accept and emit when the pipe is full is allowed: in_ready=1 in that cycle.
- in_valid may drop without an accept. Operands are sampled only on accept.
- Arithmetic: full NUMB_BITS-wide add with carry_in; sum wraps modulo 2^NUMB_BITS.
- The overflow flavour follows the signed_mode value captured with that transaction, so mode may change every transaction.
- NUM_STAGES=1: a single register stage with latency 1, functionally a registered version of the existing combinational adder.

Test Plan:
- Defaults. a=0x00FF, b=0x0001, cin=0, unsigned -> after 4 cycles: sum=0x0100, carry_out=0, overflow=0. Checks the carry crossing the chunk 1 boundary.
- a=0xFFFF, b=0x0001, cin=0: unsigned -> sum=0x0000, carry_out=1, overflow=1. Same operands with signed_mode=1 -> overflow=0.
- Signed a=0x7FFF, b=0x0001 -> sum=0x8000, carry_out=0, overflow=1. Signed a=0x8000, b=0xFFFF -> sum=0x7FFF, carry_out=1, overflow=1.
- out_ready=0, in_valid=1 with 6 distinct pairs -> exactly 4 accepted, then in_ready=0. Raise out_ready -> 6 results in order, one per cycle, in_ready=1 each cycle. Outputs stay stable while stalled.
- Streaming 20 random pairs with out_ready toggling randomly -> every result matches the reference model, with no loss, duplication or reorder.
- Assert rst for 1 cycle with 3 transactions in flight -> out_valid=0 next cycle, none of the 3 is ever emitted, and a new pair accepted afterwards yields the correct sum 4 cycles later.
